// File: rtl/slavefifo2b_mode_arbiter.sv
// Grants the shared FX3 Slave FIFO 2-bit bus to one of four sub-blocks.
// Debounces the mode request and switches owner only after the current one drains.
module slavefifo2b_mode_arbiter #(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned QUIET_CYCLES  = 4,
   parameter int unsigned DRAIN_TIMEOUT = 1024,
   parameter logic [1:0]  FADDR_WR      = 2'b00,
   parameter logic [1:0]  FADDR_RD      = 2'b11
) (
   input  logic         clk_100,
   input  logic         reset_,
   input  logic [2:0]   mode_req,
   input  logic [3:0]   slwr_in_,
   input  logic [3:0]   slrd_in_,
   input  logic [3:0]   sloe_in_,
   input  logic [3:0]   pktend_in_,
   input  logic [127:0] data_in,
   input  logic [1:0]   faddr_lb,
   output logic [3:0]   mode_selected,
   output logic         slwr_,
   output logic         slrd_,
   output logic         sloe_,
   output logic         pktend_,
   output logic [1:0]   faddr,
   output logic [31:0]  data_out,
   output logic         busy,
   output logic         drain_timeout
);

   localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);
   localparam int unsigned DW = $clog2(DRAIN_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [1:0]    cur, cur_nxt;
   logic [QW-1:0] quiet_cnt, quiet_nxt;
   logic [DW-1:0] drain_cnt, drain_nxt;
   logic          timeout_nxt;

   logic [2:0]    req_q;
   logic [SW-1:0] stable_cnt;
   logic          req_valid;
   logic          target_vld;
   logic [1:0]    target;

   logic          quiet_now;
   logic          quiet_done;
   logic          timed_out;

   // Request filter: a code must be held unchanged for STABLE_CYCLES samples.
   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_) begin
         req_q      <= '0;
         stable_cnt <= '0;
      end else begin
         req_q <= mode_req;
         if (mode_req != req_q)
            stable_cnt <= '0;
         else if (stable_cnt != SW'(STABLE_CYCLES))
            stable_cnt <= stable_cnt + 1'b1;
      end
   end

   assign req_valid = (stable_cnt == SW'(STABLE_CYCLES));

   always_comb begin
      target_vld = 1'b0;
      target     = '0;
      case (req_q)
         3'd1: begin target_vld = 1'b1; target = 2'd0; end
         3'd2: begin target_vld = 1'b1; target = 2'd1; end
         3'd3: begin target_vld = 1'b1; target = 2'd2; end
         3'd4: begin target_vld = 1'b1; target = 2'd3; end
         default: begin target_vld = 1'b0; target = '0; end
      endcase
   end

   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_) begin
         state         <= IDLE;
         cur           <= '0;
         quiet_cnt     <= '0;
         drain_cnt     <= '0;
         drain_timeout <= 1'b0;
      end else begin
         state         <= state_nxt;
         cur           <= cur_nxt;
         quiet_cnt     <= quiet_nxt;
         drain_cnt     <= drain_nxt;
         drain_timeout <= timeout_nxt;
      end
   end

   assign quiet_now  = slwr_in_[cur] & slrd_in_[cur] & pktend_in_[cur];
   assign quiet_done = (quiet_cnt == QW'(QUIET_CYCLES));
   assign timed_out  = (drain_cnt == DW'(DRAIN_TIMEOUT - 1));

   always_comb begin
      state_nxt   = state;
      cur_nxt     = cur;
      quiet_nxt   = quiet_cnt;
      drain_nxt   = drain_cnt;
      timeout_nxt = drain_timeout;
      case (state)
         IDLE: begin
            if (req_valid && target_vld) begin
               state_nxt = ACTIVE;
               cur_nxt   = target;
            end
         end
         ACTIVE: begin
            if (req_valid && (!target_vld || (target != cur))) begin
               state_nxt = DRAIN;
               quiet_nxt = '0;
               drain_nxt = '0;
            end
         end
         DRAIN: begin
            // Target is sampled at exit, so a request that settled back on cur re-grants it.
            if (quiet_done || timed_out) begin
               if (timed_out)
                  timeout_nxt = 1'b1;
               if (target_vld) begin
                  state_nxt = ACTIVE;
                  cur_nxt   = target;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               quiet_nxt = quiet_now ? quiet_cnt + 1'b1 : '0;
               drain_nxt = drain_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pad mux keeps routing cur through DRAIN so an in-flight write or pktend completes.
   always_comb begin
      mode_selected = '0;
      busy          = (state == DRAIN);
      slwr_         = 1'b1;
      slrd_         = 1'b1;
      sloe_         = 1'b1;
      pktend_       = 1'b1;
      faddr         = FADDR_WR;
      data_out      = '0;
      if (state == ACTIVE)
         mode_selected[cur] = 1'b1;
      if (state != IDLE) begin
         slwr_   = slwr_in_[cur];
         slrd_   = slrd_in_[cur];
         sloe_   = sloe_in_[cur];
         pktend_ = pktend_in_[cur];
         case (cur)
            2'd0: begin data_out = data_in[31:0];   faddr = FADDR_WR; end
            2'd1: begin data_out = data_in[63:32];  faddr = FADDR_RD; end
            2'd2: begin data_out = data_in[95:64];  faddr = faddr_lb; end
            default: begin data_out = data_in[127:96]; faddr = FADDR_WR; end
         endcase
      end
   end

endmodule

// File: tb/tb_slavefifo2b_mode_arbiter.sv
// Randomized bench for slavefifo2b_mode_arbiter against a channel-grant reference model.
// Inputs change 1 ns after each rising edge; outputs are compared 2 ns after it.
module tb_slavefifo2b_mode_arbiter;

   localparam int STABLE = 16;
   localparam int QUIET  = 4;
   localparam int DTO    = 1024;
   localparam logic [43:0] RST_VEC = {4'b0000, 4'b1111, 2'b00, 32'h0, 1'b0, 1'b0};

   logic         clk_100 = 1'b0;
   logic         reset_;
   logic [2:0]   mode_req;
   logic [3:0]   slwr_in_, slrd_in_, sloe_in_, pktend_in_;
   logic [127:0] data_in;
   logic [1:0]   faddr_lb;
   logic [3:0]   mode_selected;
   logic         slwr_, slrd_, sloe_, pktend_;
   logic [1:0]   faddr;
   logic [31:0]  data_out;
   logic         busy, drain_timeout;
   logic [43:0]  obs;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: owner channel (-1 = none), draining flag, counters as plain ints.
   int m_prev, m_stable, m_grant, m_quiet, m_dcnt;
   bit m_drain, m_tout;

   always #5 clk_100 = ~clk_100;

   assign obs = {mode_selected, slwr_, slrd_, sloe_, pktend_, faddr, data_out, busy, drain_timeout};

   slavefifo2b_mode_arbiter #(
      .STABLE_CYCLES(STABLE),
      .QUIET_CYCLES (QUIET),
      .DRAIN_TIMEOUT(DTO),
      .FADDR_WR     (2'b00),
      .FADDR_RD     (2'b11)
   ) dut (
      .clk_100      (clk_100),
      .reset_       (reset_),
      .mode_req     (mode_req),
      .slwr_in_     (slwr_in_),
      .slrd_in_     (slrd_in_),
      .sloe_in_     (sloe_in_),
      .pktend_in_   (pktend_in_),
      .data_in      (data_in),
      .faddr_lb     (faddr_lb),
      .mode_selected(mode_selected),
      .slwr_        (slwr_),
      .slrd_        (slrd_),
      .sloe_        (sloe_),
      .pktend_      (pktend_),
      .faddr        (faddr),
      .data_out     (data_out),
      .busy         (busy),
      .drain_timeout(drain_timeout)
   );

   function automatic int decode(input int r);
      return (r >= 1 && r <= 4) ? r - 1 : -1;
   endfunction

   task automatic model_reset();
      m_prev = 0; m_stable = 0; m_grant = -1;
      m_quiet = 0; m_dcnt = 0; m_drain = 0; m_tout = 0;
   endtask

   task automatic model_edge();
      bit valid;
      int tgt;
      valid = (m_stable >= STABLE);
      tgt   = decode(m_prev);
      if (m_drain) begin
         if (m_quiet == QUIET || m_dcnt == DTO - 1) begin
            if (m_dcnt == DTO - 1) m_tout = 1;
            m_grant = tgt;
            m_drain = 0;
         end else begin
            if (slwr_in_[m_grant] && slrd_in_[m_grant] && pktend_in_[m_grant]) m_quiet++;
            else m_quiet = 0;
            m_dcnt++;
         end
      end else if (m_grant < 0) begin
         if (valid && tgt >= 0) m_grant = tgt;
      end else if (valid && tgt != m_grant) begin
         m_drain = 1; m_quiet = 0; m_dcnt = 0;
      end
      if (int'(mode_req) != m_prev) m_stable = 0;
      else m_stable++;
      m_prev = int'(mode_req);
   endtask

   function automatic logic [43:0] exp_vec();
      logic [3:0]  sel;
      logic [3:0]  s;
      logic [1:0]  fa;
      logic [31:0] d;
      sel = '0; s = 4'hf; fa = 2'b00; d = '0;
      if (m_grant >= 0) begin
         if (!m_drain) sel = 4'b0001 << m_grant;
         s  = {slwr_in_[m_grant], slrd_in_[m_grant], sloe_in_[m_grant], pktend_in_[m_grant]};
         d  = data_in[32*m_grant +: 32];
         fa = (m_grant == 1) ? 2'b11 : (m_grant == 2) ? faddr_lb : 2'b00;
      end
      return {sel, s, fa, d, m_drain, m_tout};
   endfunction

   task automatic tick();
      @(posedge clk_100);
      model_edge();
      cyc++;
      #1;
   endtask

   task automatic rand_inputs();
      data_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
      faddr_lb   = 2'($urandom_range(0, 3));
      slwr_in_   = 4'($urandom());
      slrd_in_   = 4'($urandom());
      sloe_in_   = 4'($urandom());
      pktend_in_ = 4'($urandom());
   endtask

   task automatic test_reset();
      reset_   = 1'b0;
      mode_req = 3'd4;
      rand_inputs();
      slwr_in_ = 4'b0000;
      model_reset();
      #22;
      if (obs !== RST_VEC) begin
         errors++; $display("FAIL reset_values got=%h exp=%h", obs, RST_VEC);
      end
      checks++;
      rand_inputs();
      pktend_in_ = 4'b0000;
      #1;
      if (obs !== RST_VEC) begin
         errors++; $display("FAIL reset_pads_idle got=%h exp=%h", obs, RST_VEC);
      end
      checks++;
      @(posedge clk_100);
      #1 reset_ = 1'b1;
      cyc = 0;
   endtask

   task automatic test_startup();
      logic [3:0] esel;
      for (int e = 1; e <= 25; e++) begin
         tick();
         rand_inputs();
         #1;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL startup cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         checks++;
         esel = (e >= 18) ? 4'b1000 : 4'b0000;
         if (mode_selected !== esel) begin
            errors++; $display("FAIL startup_sel edge=%0d got=%b exp=%b", e, mode_selected, esel);
         end
         checks++;
      end
   endtask

   task automatic test_glitch();
      bit busy_seen = 0;
      for (int e = 1; e <= 30; e++) begin
         tick();
         rand_inputs();
         mode_req = (e >= 2 && e <= 5) ? 3'd1 : 3'd4;
         #1;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         checks++;
         if (busy) busy_seen = 1;
      end
      if (busy_seen !== 1'b0 || mode_selected !== 4'b1000) begin
         errors++; $display("FAIL glitch_no_drain got=%b/%b exp=0/1000", busy_seen, mode_selected);
      end
      checks++;
   endtask

   task automatic test_switch();
      bit got = 0;
      int bcnt;
      for (int e = 0; e < 40 && !got; e++) begin
         tick();
         rand_inputs();
         mode_req = 3'd2;
         slwr_in_[3] = 1'b0; slrd_in_[3] = 1'b1; pktend_in_[3] = 1'b1;
         #1;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL switch_pre cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         checks++;
         if (busy) got = 1;
      end
      if (!got) begin
         errors++; $display("FAIL switch_entry got=busy0 exp=busy1 within 40 cycles");
      end
      checks++;
      bcnt = 1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         rand_inputs();
         slwr_in_[3] = (k <= 5) ? 1'b0 : 1'b1; slrd_in_[3] = 1'b1; pktend_in_[3] = 1'b1;
         #1;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL switch_drain cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         checks++;
         if (busy) bcnt++;
      end
      if (bcnt != 11) begin
         errors++; $display("FAIL switch_busy_len got=%0d exp=11", bcnt);
      end
      checks++;
      if (faddr !== 2'b11 || mode_selected !== 4'b0010) begin
         errors++; $display("FAIL switch_final got=%b/%b exp=11/0010", faddr, mode_selected);
      end
      checks++;
   endtask

   task automatic test_loopback_none();
      mode_req = 3'd3;
      for (int e = 0; e < 40; e++) begin
         tick();
         rand_inputs();
         slwr_in_[1] = 1'b1; slrd_in_[1] = 1'b1; pktend_in_[1] = 1'b1;
         #1;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL lb_enter cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         checks++;
      end
      if (mode_selected !== 4'b0100 || faddr !== faddr_lb) begin
         errors++; $display("FAIL lb_active got=%b/%b exp=0100/%b", mode_selected, faddr, faddr_lb);
      end
      checks++;
      mode_req = 3'd6;
      for (int e = 0; e < 40; e++) begin
         tick();
         rand_inputs();
         slwr_in_[2] = 1'b1; slrd_in_[2] = 1'b1; pktend_in_[2] = 1'b1;
         #1;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL lb_none cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         checks++;
      end
      tick();
      rand_inputs();
      slwr_in_[2] = 1'b0;
      #1;
      if ({mode_selected, slwr_, slrd_, sloe_, pktend_, faddr, data_out} !== {4'b0000, 4'b1111, 2'b00, 32'h0}) begin
         errors++; $display("FAIL idle_pads got=%b %b%b%b%b %b %h exp=0000 1111 00 0",
                            mode_selected, slwr_, slrd_, sloe_, pktend_, faddr, data_out);
      end
      checks++;
   endtask

   task automatic test_stuck_drain();
      bit got = 0;
      int dcnt;
      mode_req = 3'd1;
      for (int e = 0; e < 30; e++) begin
         tick();
         rand_inputs();
         #1;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL stuck_setup cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         checks++;
      end
      mode_req = 3'd4;
      for (int e = 0; e < 40 && !got; e++) begin
         tick();
         rand_inputs();
         pktend_in_[0] = 1'b0;
         #1;
         if (busy) got = 1;
      end
      if (!got) begin
         errors++; $display("FAIL stuck_entry got=busy0 exp=busy1 within 40 cycles");
      end
      checks++;
      dcnt = 1;
      for (int e = 0; e < 1100 && busy; e++) begin
         tick();
         rand_inputs();
         pktend_in_[0] = 1'b0;
         #1;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL stuck_drain cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         checks++;
         if (busy) dcnt++;
      end
      if (dcnt != DTO) begin
         errors++; $display("FAIL stuck_len got=%0d exp=%0d", dcnt, DTO);
      end
      checks++;
      if (drain_timeout !== 1'b1 || mode_selected !== 4'b1000) begin
         errors++; $display("FAIL stuck_exit got=%b/%b exp=1/1000", drain_timeout, mode_selected);
      end
      checks++;
      for (int e = 0; e < 5; e++) begin
         tick();
         rand_inputs();
         #1;
         if (drain_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky cyc=%0d got=%b exp=1", cyc, drain_timeout);
         end
         checks++;
      end
   endtask

   task automatic test_random();
      int hold = 0;
      int g;
      for (int e = 0; e < 1500; e++) begin
         tick();
         if (hold == 0) begin
            mode_req = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 40);
         end
         hold--;
         rand_inputs();
         g = m_grant;
         if (g >= 0) begin
            slwr_in_[g] = 1'b1; slrd_in_[g] = 1'b1; pktend_in_[g] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
               case ($urandom_range(0, 2))
                  0: slwr_in_[g] = 1'b0;
                  1: slrd_in_[g] = 1'b0;
                  default: pktend_in_[g] = 1'b0;
               endcase
            end
         end
         #1;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         checks++;
      end
   endtask

   task automatic test_reset_mid_drain();
      bit got = 0;
      logic [3:0] esel;
      mode_req = 3'd2;
      for (int e = 0; e < 60; e++) begin
         tick();
         rand_inputs();
         slwr_in_ = 4'hf; slrd_in_ = 4'hf; pktend_in_ = 4'hf;
         #1;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL rmd_setup cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         checks++;
      end
      mode_req = 3'd1;
      for (int e = 0; e < 40 && !got; e++) begin
         tick();
         rand_inputs();
         slwr_in_[1] = 1'b0;
         #1;
         if (busy) got = 1;
      end
      tick();
      rand_inputs();
      slwr_in_[1] = 1'b0;
      #1;
      if (!got || slwr_ !== 1'b0) begin
         errors++; $display("FAIL rmd_in_drain got=busy%b slwr_%b exp=busy1 slwr_0", got, slwr_);
      end
      checks++;
      #2 reset_ = 1'b0;
      #1;
      if (obs !== RST_VEC) begin
         errors++; $display("FAIL rmd_async got=%h exp=%h", obs, RST_VEC);
      end
      checks++;
      model_reset();
      repeat (2) @(posedge clk_100);
      #1 reset_ = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         rand_inputs();
         #1;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL rmd_restart cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         checks++;
         esel = (e >= 18) ? 4'b0001 : 4'b0000;
         if (mode_selected !== esel) begin
            errors++; $display("FAIL rmd_filter edge=%0d got=%b exp=%b", e, mode_selected, esel);
         end
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_glitch();
      test_switch();
      test_loopback_none();
      test_stuck_drain();
      test_random();
      test_reset_mid_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
